// File: rtl/friscv_fence_pkg.sv
// Shared definitions for the FENCE drain controller: state encoding and
// predecessor-set bit positions.
package friscv_fence_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLOCK = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fence_state_t;

   // Bit positions inside fence_pred / pred_q
   localparam int FENCE_PRED_W = 0;
   localparam int FENCE_PRED_R = 1;

   // Ordering satisfied: no request mid-handshake and no selected completions outstanding
   function automatic logic fence_drain_ok(
      input logic [1:0] pred,
      input logic       issue_pending,
      input logic       waiting_wr_cpl,
      input logic       waiting_rd_cpl
   );
      return !issue_pending
          && !(pred[FENCE_PRED_W] && waiting_wr_cpl)
          && !(pred[FENCE_PRED_R] && waiting_rd_cpl);
   endfunction

endpackage

// File: rtl/friscv_fence_timer.sv
// Drain watchdog: saturating counter with synchronous clear and count enable.
// expire flags the last permitted drain cycle (count == TIMEOUT-1).
module friscv_fence_timer
   import friscv_fence_pkg::*;
#(
   parameter int TIMEOUT_W = 16,
   parameter int TIMEOUT   = 4096
) (
   input  logic aclk,
   input  logic srst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [TIMEOUT_W-1:0] count_q;

   // Count enabled cycles, hold at all-ones, restart on clear
   always_ff @(posedge aclk) begin
      if (srst || clear) begin
         count_q <= '0;
      end else if (enable && (count_q != {TIMEOUT_W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expire = (count_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/friscv_fence_drain.sv
// FENCE drain controller. Accepts a fence, blocks new AR/AW issue, waits for
// the selected outstanding reads/writes to retire, then pulses fence_done.
// Optional drain watchdog compiled in with FRISCV_FENCE_TIMEOUT_EN.
module friscv_fence_drain
   import friscv_fence_pkg::*;
#(
   parameter     NAME      = "Fence_Drain",
   parameter int TIMEOUT_W = 16,
   parameter int TIMEOUT   = 4096
) (
   input  logic       aclk,
   input  logic       srst,
   input  logic       fence_valid,
   output logic       fence_ready,
   input  logic [1:0] fence_pred,
   input  logic       issue_pending,
   input  logic       waiting_wr_cpl,
   input  logic       waiting_rd_cpl,
   output logic       req_block,
   output logic       fence_busy,
   output logic       fence_done,
   output logic       fence_timeout
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_BLOCK = BLOCK;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_DONE  = DONE;

   if ((TIMEOUT < 1) || (TIMEOUT > (2 ** TIMEOUT_W) - 1)) begin : g_bad_timeout
      $error("%s: TIMEOUT out of range for TIMEOUT_W", NAME);
   end

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic [1:0] pred_q;
   logic       accept;
   logic       drain_ok;
   logic       wd_expire;
   logic       wd_fire;

   assign accept   = fence_valid && fence_ready;
   assign drain_ok = fence_drain_ok(pred_q, issue_pending, waiting_wr_cpl, waiting_rd_cpl);
   assign wd_fire  = (state_q == ST_DRAIN) && !drain_ok && wd_expire;

   // Next-state decode; status inputs only matter in DRAIN
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = (fence_pred == 2'b00) ? ST_DONE : ST_BLOCK;
         ST_BLOCK: state_d = ST_DRAIN;
         ST_DRAIN: if (drain_ok || wd_fire) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register and predecessor-set capture on the fence handshake
   always_ff @(posedge aclk) begin
      if (srst) begin
         state_q <= ST_IDLE;
         pred_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         if (accept) pred_q <= fence_pred;
      end
   end

   assign fence_ready = (state_q == ST_IDLE);
   assign req_block   = (state_q == ST_BLOCK) || (state_q == ST_DRAIN);
   assign fence_busy  = (state_q != ST_IDLE);
   assign fence_done  = (state_q == ST_DONE);

`ifdef FRISCV_FENCE_TIMEOUT_EN
   logic timeout_q;

   // BLOCK always precedes DRAIN, so clearing there restarts the count on DRAIN entry
   friscv_fence_timer #(
      .TIMEOUT_W (TIMEOUT_W),
      .TIMEOUT   (TIMEOUT)
   ) u_timer (
      .aclk   (aclk),
      .srst   (srst),
      .clear  (state_q == ST_BLOCK),
      .enable (state_q == ST_DRAIN),
      .expire (wd_expire)
   );

   // Sticky timeout flag, cleared by the next accepted fence
   always_ff @(posedge aclk) begin
      if (srst) begin
         timeout_q <= 1'b0;
      end else if (accept) begin
         timeout_q <= 1'b0;
      end else if (wd_fire) begin
         timeout_q <= 1'b1;
      end
   end

   assign fence_timeout = timeout_q;

`ifndef SYNTHESIS
   // Simulation notice when the watchdog ends a drain
   always_ff @(posedge aclk) begin
      if (!srst && wd_fire) $display("ERROR: %s: fence drain timeout", NAME);
   end
`endif
`else
   assign wd_expire     = 1'b0;
   assign fence_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_friscv_fence_drain.sv
// Directed bench for friscv_fence_drain. Inputs change 1 time unit after the
// rising edge and outputs are checked at that same point.
module tb_friscv_fence_drain;

   localparam int TB_TIMEOUT = 8;
`ifdef FRISCV_FENCE_TIMEOUT_EN
   localparam int WR_HOLD = 6;
`else
   localparam int WR_HOLD = 10;
`endif

   logic       aclk;
   logic       srst;
   logic       fence_valid;
   logic       fence_ready;
   logic [1:0] fence_pred;
   logic       issue_pending;
   logic       waiting_wr_cpl;
   logic       waiting_rd_cpl;
   logic       req_block;
   logic       fence_busy;
   logic       fence_done;
   logic       fence_timeout;

   int errors = 0;
   int checks = 0;

   friscv_fence_drain #(
      .NAME      ("Fence_Drain"),
      .TIMEOUT_W (16),
      .TIMEOUT   (TB_TIMEOUT)
   ) dut (
      .aclk           (aclk),
      .srst           (srst),
      .fence_valid    (fence_valid),
      .fence_ready    (fence_ready),
      .fence_pred     (fence_pred),
      .issue_pending  (issue_pending),
      .waiting_wr_cpl (waiting_wr_cpl),
      .waiting_rd_cpl (waiting_rd_cpl),
      .req_block      (req_block),
      .fence_busy     (fence_busy),
      .fence_done     (fence_done),
      .fence_timeout  (fence_timeout)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Present a fence for exactly one edge; returns in cycle 1 after the handshake
   task automatic fence(input logic [1:0] pred);
      chk("fence_ready_before_hs", fence_ready, 1'b1);
      fence_valid = 1'b1;
      fence_pred  = pred;
      tick();
      fence_valid = 1'b0;
      fence_pred  = 2'b00;
   endtask

   initial begin
      srst           = 1'b1;
      fence_valid    = 1'b0;
      fence_pred     = 2'b00;
      issue_pending  = 1'b0;
      waiting_wr_cpl = 1'b0;
      waiting_rd_cpl = 1'b0;
      tick();
      tick();
      srst = 1'b0;

      // Reset idle
      chk("rst_ready",   fence_ready,   1'b1);
      chk("rst_block",   req_block,     1'b0);
      chk("rst_busy",    fence_busy,    1'b0);
      chk("rst_done",    fence_done,    1'b0);
      chk("rst_timeout", fence_timeout, 1'b0);

      // Empty predecessor set: DONE in cycle 1, never blocks
      fence(2'b00);
      chk("p00_c1_done",  fence_done,  1'b1);
      chk("p00_c1_block", req_block,   1'b0);
      chk("p00_c1_busy",  fence_busy,  1'b1);
      chk("p00_c1_ready", fence_ready, 1'b0);
      tick();
      chk("p00_c2_done",  fence_done,  1'b0);
      chk("p00_c2_block", req_block,   1'b0);
      chk("p00_c2_ready", fence_ready, 1'b1);

      // Quiet bus, pred=11: block in cycles 1-2, done in cycle 3
      fence(2'b11);
      chk("quiet_c1_block", req_block,   1'b1);
      chk("quiet_c1_done",  fence_done,  1'b0);
      chk("quiet_c1_ready", fence_ready, 1'b0);
      tick();
      chk("quiet_c2_block", req_block,  1'b1);
      chk("quiet_c2_done",  fence_done, 1'b0);
      tick();
      chk("quiet_c3_done",  fence_done, 1'b1);
      chk("quiet_c3_block", req_block,  1'b0);
      tick();
      chk("quiet_c4_idle",  fence_busy, 1'b0);
      chk("quiet_c4_done",  fence_done, 1'b0);

      // Write drain, pred=01: reads outstanding throughout are ignored
      waiting_rd_cpl = 1'b1;
      waiting_wr_cpl = 1'b1;
      fence(2'b01);
      chk("wr_block_state", req_block, 1'b1);
      tick();
      for (int k = 0; k < WR_HOLD; k++) begin
         chk("wr_hold_block", req_block,  1'b1);
         chk("wr_hold_done",  fence_done, 1'b0);
         tick();
      end
      waiting_wr_cpl = 1'b0;
      chk("wr_fall_block", req_block,  1'b1);
      chk("wr_fall_done",  fence_done, 1'b0);
      tick();
      chk("wr_done",       fence_done,    1'b1);
      chk("wr_done_block", req_block,     1'b0);
      chk("wr_no_timeout", fence_timeout, 1'b0);
      tick();
      waiting_rd_cpl = 1'b0;
      chk("wr_idle", fence_busy, 1'b0);

      // Pending issue, pred=10: issue_pending for 3 DRAIN cycles, writes ignored
      waiting_wr_cpl = 1'b1;
      fence(2'b10);
      issue_pending = 1'b1;
      chk("pend_block_state", req_block, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("pend_hold_block", req_block,  1'b1);
         chk("pend_hold_done",  fence_done, 1'b0);
         tick();
      end
      issue_pending = 1'b0;
      chk("pend_c3_block", req_block,  1'b1);
      chk("pend_c3_done",  fence_done, 1'b0);
      tick();
      chk("pend_c4_done",  fence_done,  1'b1);
      chk("pend_c4_block", req_block,   1'b0);
      chk("pend_c4_ready", fence_ready, 1'b0);
      tick();
      waiting_wr_cpl = 1'b0;
      chk("pend_idle", fence_ready, 1'b1);

`ifdef FRISCV_FENCE_TIMEOUT_EN
      // Watchdog: reads stuck, DONE after TB_TIMEOUT DRAIN cycles
      waiting_rd_cpl = 1'b1;
      fence(2'b11);
      tick();
      for (int k = 0; k < TB_TIMEOUT; k++) begin
         chk("wd_hold_block",   req_block,     1'b1);
         chk("wd_hold_done",    fence_done,    1'b0);
         chk("wd_hold_timeout", fence_timeout, 1'b0);
         tick();
      end
      chk("wd_done",       fence_done,    1'b1);
      chk("wd_timeout",    fence_timeout, 1'b1);
      chk("wd_done_block", req_block,     1'b0);
      tick();
      waiting_rd_cpl = 1'b0;
      chk("wd_sticky", fence_timeout, 1'b1);
      fence(2'b00);
      chk("wd_clear_done",    fence_done,    1'b1);
      chk("wd_clear_timeout", fence_timeout, 1'b0);
      tick();
`else
      // No watchdog: a long stall stays in DRAIN until reads retire
      waiting_rd_cpl = 1'b1;
      fence(2'b10);
      tick();
      for (int k = 0; k < 40; k++) begin
         chk("stall_block", req_block,  1'b1);
         chk("stall_done",  fence_done, 1'b0);
         tick();
      end
      waiting_rd_cpl = 1'b0;
      tick();
      chk("stall_done_end", fence_done,    1'b1);
      chk("stall_timeout",  fence_timeout, 1'b0);
      tick();
`endif

      // Reset in DRAIN: back to IDLE, no done pulse
      waiting_wr_cpl = 1'b1;
      fence(2'b01);
      tick();
      tick();
      chk("mrst_in_drain", req_block, 1'b1);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("mrst_ready",   fence_ready,   1'b1);
      chk("mrst_block",   req_block,     1'b0);
      chk("mrst_busy",    fence_busy,    1'b0);
      chk("mrst_done",    fence_done,    1'b0);
      chk("mrst_timeout", fence_timeout, 1'b0);
      waiting_wr_cpl = 1'b0;
      tick();
      chk("mrst_after_done", fence_done, 1'b0);
      chk("mrst_after_busy", fence_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/friscv_fence_drain.md
# friscv_fence_drain

Memory-ordering drain controller for FENCE instructions, sitting directly downstream of the AXI outstanding-request tracker's status outputs. It accepts a fence command from the processing unit and immediately blocks new memory request issue. It then waits until every outstanding read and/or write selected by the fence's predecessor set has completed, and only then acknowledges the fence. An optional watchdog bounds the wait.

## Interface
- NAME, "Fence_Drain": instance name used in simulation messages
- TIMEOUT_W, 16: width of the drain watchdog counter
- TIMEOUT, 4096: drain cycles before watchdog fires; legal range 1 .. 2^TIMEOUT_W-1
- aclk  in  1  clock
- srst  in  1  synchronous active-high reset
- fence_valid  in  1  fence command valid
- fence_ready  out  1  controller can accept a fence
- fence_pred  in  2  predecessor set: bit1 = reads, bit0 = writes
- issue_pending  in  1  an AR or AW request is presented but not yet handshaked
- waiting_wr_cpl  in  1  write completions outstanding, from the OR tracker
- waiting_rd_cpl  in  1  read completions outstanding, from the OR tracker
- req_block  out  1  forbids issuing new AR/AW requests
- fence_busy  out  1  controller is not idle
- fence_done  out  1  one-cycle pulse: fence ordering satisfied
- fence_timeout  out  1  sticky flag: last fence ended by the watchdog

## Operation
- FSM states and outputs:
  - IDLE: fence_ready=1.
  - BLOCK: req_block=1. Lets a request already on the bus finish its handshake.
  - DRAIN: req_block=1.
  - DONE: fence_done=1.
  - fence_busy = state != IDLE.
- IDLE transitions, on fence_valid && fence_ready:
  - Capture fence_pred into pred_q.
  - pred_q == 2'b00 -> DONE.
  - Otherwise -> BLOCK.
- BLOCK -> DRAIN unconditionally.
- DRAIN -> DONE when drain_ok:
  - drain_ok = !issue_pending && !(pred_q[0] && waiting_wr_cpl) && !(pred_q[1] && waiting_rd_cpl).
- DONE -> IDLE unconditionally.
- Status inputs are sampled while in DRAIN only; values in other states are ignored.
- Upstream serialises fences: it issues no AR/AW in the fence handshake cycle.
- fence_valid arriving in any state other than IDLE is not accepted (fence_ready=0).
- fence_timeout is cleared on the next accepted fence and on srst.

## Timing
- All outputs are registered or decoded from the registered state. There is no combinational input-to-output path, except fence_ready, which is a state decode only.
- Reset values: state IDLE, fence_ready=1, req_block=0, fence_busy=0, fence_done=0, fence_timeout=0, pred_q=0, watchdog count=0.
- Handshake at edge 0, pred=0: fence_done high in cycle 1. Next fence can be accepted in cycle 2.
- Handshake at edge 0, pred≠0, drain_ok true: BLOCK in cycle 1, DRAIN in cycle 2, fence_done in cycle 3.
- Each additional cycle with drain_ok false adds one cycle of latency.
- req_block rises in cycle 1 after the handshake and falls in the DONE cycle.
- srst mid-fence: return to IDLE next edge, outputs take reset values, no fence_done pulse. Upstream must reissue the fence.

## Configuration
- FRISCV_FENCE_TIMEOUT_EN defined:
  - The watchdog counts DRAIN cycles, saturating and cleared on DRAIN entry.
  - When count == TIMEOUT-1 and drain_ok is false, the FSM goes to DONE and sets fence_timeout.
  - A simulation-only $display "ERROR: <NAME>: fence drain timeout" is emitted.
- FRISCV_FENCE_TIMEOUT_EN undefined:
  - No counter logic is compiled in.
  - fence_timeout is tied to 0.
  - DRAIN waits indefinitely for drain_ok.

## Structure
- Shared package friscv_fence_pkg:
  - fence_state_t enum (IDLE, BLOCK, DRAIN, DONE).
  - Predecessor bit index constants FENCE_PRED_W=0 and FENCE_PRED_R=1.
- One sub-module, friscv_fence_timer:
  - Contents: saturating TIMEOUT_W counter with clear, enable and expire outputs.
  - Instantiated only under FRISCV_FENCE_TIMEOUT_EN.

## Test plan
- Reset idle: after srst, fence_ready=1, all other outputs 0. A fence with pred=00 gives fence_done in cycle 1 and req_block is never asserted.
- Quiet bus: pred=11, both waiting inputs 0, issue_pending 0 -> req_block high in cycles 1–2, fence_done in cycle 3.
- Write drain: pred=01, waiting_wr_cpl held 1 for 10 cycles after DRAIN entry, waiting_rd_cpl held 1 throughout -> fence_done exactly one cycle after waiting_wr_cpl falls. Reads are ignored.
- Pending issue: pred=10, issue_pending high 3 cycles into DRAIN, waiting_rd_cpl 0 -> fence_done on cycle 4 of DRAIN. req_block stays 1 throughout.
- Watchdog (macro on, TIMEOUT=8): pred=11, waiting_rd_cpl stuck 1 -> DONE after 8 DRAIN cycles with fence_timeout=1. The flag clears on the next accepted fence.
- Mid-fence reset: srst in DRAIN -> next cycle IDLE, req_block=0, no fence_done pulse, fence_timeout=0.
